jtkunio_mbox: RTL and testbench
===============================

// Module: jtkunio_mbox
// PURPOSE
// - Bidirectional mailbox between the main 6502 and the protection MCU / sound CPU.
// - Replaces the single-byte latch and the hard-wired MCU status bits.
// - Two independent FIFOs: A->B (main to MCU) and B->A (MCU to main).
// - Each side gets status flags and an interrupt request.
// - Sits beside the main CPU address decoder. Side A is driven by the main-CPU chip
//   selects, side B by the MCU port logic.
// PARAMETERS
// - DW     8  data width of both FIFOs.
// - DEPTH  1  entries per FIFO. Power of two, range 1..16. DEPTH=1 behaves as a plain latch.
// - AW     $clog2(DEPTH), min 1. Derived; do not override.
// PORTS
// - clk      in   1   system clock (24 MHz)
// - rst      in   1   synchronous, active-high reset
// - a_wr     in   1   side A write select, level: cs & ~rnw, held for the whole access
// - a_rd     in   1   side A read select, level
// - a_din    in   DW  side A write data
// - a_dout   out  DW  head of B->A FIFO
// - a_st     out  2   {a2b_full, b2a_nempty}
// - a_ovf    out  1   sticky: A wrote while A->B was full
// - a_irq    out  1   interrupt to side A
// - a_irqclr in   1   one-cycle pulse; clears a_irq (only with macro)
// - b_wr, b_rd, b_din, b_dout, b_st, b_ovf, b_irq, b_irqclr
//                     mirror of side A for side B. b_st={b2a_full, a2b_nempty}.
// BEHAVIOUR
// - Reset (sync): both FIFOs empty. Pointers and counters = 0. *_dout=0, *_st=0, *_ovf=0, *_irq=0.
// - Edge detector registers for *_wr/*_rd reset to 1, so a select held across reset
//   produces no event.
// - Push: rising edge of *_wr, registered one cycle (event on the cycle after *_wr is
//   first seen high). Data is sampled from *_din on that same cycle.
// - Pop: falling edge of *_rd. The CPU sees a stable head for the whole access; the
//   head advances one cycle after *_rd drops.
// - *_dout is registered and updated one cycle after any push or pop that changes the head.
// - Empty pop: ignored. *_dout holds the last value. Count stays 0.
// - Full push: data dropped, FIFO unchanged, that side's *_ovf set. *_ovf clears only on rst.
// - Push and pop on the same FIFO in the same cycle: both happen.
//   - When full: the pop frees the slot and the push is accepted. Count unchanged, no overflow.
//   - When empty: the push lands and is popped immediately. dout shows the pushed value,
//     count stays 0.
// - Pointers are AW bits and wrap modulo DEPTH. The count is AW+1 bits, range 0..DEPTH.
// - full = (count==DEPTH); nempty = (count!=0). Both registered, valid the cycle after the event.
// - IRQ, default mode (level): b_irq = a2b_nempty and a_irq = b2a_nempty.
//   *_irqclr is ignored.
// - Side A and side B events are independent and may coincide on any cycle.
// CONFIGURATION
// - JTKUNIO_MBOX_IRQLATCH_EN defined: IRQ becomes latched.
//   - b_irq is set by an accepted A->B push and cleared by a b_irqclr pulse.
//   - Set wins over a simultaneous clear.
//   - Side A mirrors this.
//   - A dropped (overflow) push does not set the IRQ.
// - Not defined: level mode as above. The *_irqclr ports exist but are unused.
// TESTING
// - DEPTH=1: A writes 8'h5A -> b_st=2'b01, b_irq=1.
//   - B read edge -> b_dout=8'h5A.
//   - One cycle after the falling edge of b_rd -> b_st=0, b_irq=0.
// - DEPTH=4: A writes 11,22,33,44,55.
//   - a_st[1]=1 after the 4th write. a_ovf=1 after the 5th.
//   - B pops 11,22,33,44 in order. 55 is never seen.
// - DEPTH=4 full: B pop and A push of 8'h66 on the same cycle -> no overflow, count stays 4,
//   8'h66 is the last entry.
// - Empty read: B pops with no data -> b_dout holds the previous value, count 0, no
//   underflow wrap.
// - rst asserted mid-transfer with a_wr held high -> everything returns to reset values
//   and no push occurs while a_wr stays high.
// - Macro defined: A push sets b_irq. b_irqclr on the same cycle as a second push
//   -> b_irq stays 1. A lone b_irqclr -> b_irq=0.

Source files
------------

// File: rtl/jtkunio_mbox.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | jtkunio_mbox : bidirectional two-FIFO mailbox, main 6502 (A) <-> MCU (B)    |
// | Optional macro JTKUNIO_MBOX_IRQLATCH_EN: latched IRQs cleared by *_irqclr   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

module jtkunio_mbox_fifo #(
   parameter int DW    = 8,
   parameter int DEPTH = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout,
   output logic          full,
   output logic          nempty,
   output logic          ovf,
   output logic          accepted
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int MEMN = 1 << AW;
   localparam logic [AW:0]   C_DEPTH = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] C_LAST  = AW'(DEPTH-1);

   logic [DW-1:0] r_mem [MEMN];
   logic [AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [AW:0]   r_cnt;
   logic [DW-1:0] r_dout;
   logic          r_full, r_nempty, r_ovf;

   logic [AW-1:0] w_wr_next, w_rd_next;
   logic [AW:0]   w_cnt_next;
   logic [DW-1:0] w_dout_next;
   logic          w_empty, w_is_full, w_pass, w_do_pop, w_do_push;

   // Explicit wrap keeps DEPTH=1 pinned to slot 0 even though AW is 1
   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == C_LAST) ? '0 : p + AW'(1);
   endfunction

   always_comb begin
      w_empty     = (r_cnt == '0);
      w_is_full   = (r_cnt == C_DEPTH);
      // Push and pop on an empty FIFO: the word passes straight to dout
      w_pass      = push & pop & w_empty;
      w_do_pop    = pop & ~w_empty;
      w_do_push   = push & ~w_pass & (~w_is_full | w_do_pop);
      w_rd_next   = w_do_pop  ? ptr_inc(r_rd_ptr) : r_rd_ptr;
      w_wr_next   = w_do_push ? ptr_inc(r_wr_ptr) : r_wr_ptr;
      w_cnt_next  = r_cnt;
      if (w_do_push && !w_do_pop)
         w_cnt_next = r_cnt + (AW+1)'(1);
      else if (w_do_pop && !w_do_push)
         w_cnt_next = r_cnt - (AW+1)'(1);
      w_dout_next = r_dout;
      if (w_pass)
         w_dout_next = din;
      else if (w_cnt_next != '0)
         w_dout_next = (w_do_push && (r_wr_ptr == w_rd_next)) ? din : r_mem[w_rd_next];
   end

   always_ff @(posedge clk) begin
      if (w_do_push)
         r_mem[r_wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
         r_dout   <= '0;
         r_full   <= 1'b0;
         r_nempty <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         r_wr_ptr <= w_wr_next;
         r_rd_ptr <= w_rd_next;
         r_cnt    <= w_cnt_next;
         r_dout   <= w_dout_next;
         r_full   <= (w_cnt_next == C_DEPTH);
         r_nempty <= (w_cnt_next != '0);
         if (push && w_is_full && !w_do_pop)
            r_ovf <= 1'b1;
      end
   end

   assign dout     = r_dout;
   assign full     = r_full;
   assign nempty   = r_nempty;
   assign ovf      = r_ovf;
   assign accepted = w_do_push | w_pass;

endmodule

module jtkunio_mbox #(
   parameter int DW    = 8,
   parameter int DEPTH = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          a_wr,
   input  logic          a_rd,
   input  logic [DW-1:0] a_din,
   output logic [DW-1:0] a_dout,
   output logic [1:0]    a_st,
   output logic          a_ovf,
   output logic          a_irq,
   input  logic          a_irqclr,
   input  logic          b_wr,
   input  logic          b_rd,
   input  logic [DW-1:0] b_din,
   output logic [DW-1:0] b_dout,
   output logic [1:0]    b_st,
   output logic          b_ovf,
   output logic          b_irq,
   input  logic          b_irqclr
);

   logic r_a_wr_d, r_a_rd_d, r_b_wr_d, r_b_rd_d;
   logic r_a_push, r_b_push;
   logic w_a_pop, w_b_pop;
   logic w_a2b_full, w_a2b_nempty, w_a2b_acc;
   logic w_b2a_full, w_b2a_nempty, w_b2a_acc;

   // Delay registers reset high so a select held through reset is not an edge
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a_wr_d <= 1'b1;
         r_a_rd_d <= 1'b1;
         r_b_wr_d <= 1'b1;
         r_b_rd_d <= 1'b1;
         r_a_push <= 1'b0;
         r_b_push <= 1'b0;
      end else begin
         r_a_wr_d <= a_wr;
         r_a_rd_d <= a_rd;
         r_b_wr_d <= b_wr;
         r_b_rd_d <= b_rd;
         r_a_push <= a_wr & ~r_a_wr_d;
         r_b_push <= b_wr & ~r_b_wr_d;
      end
   end

   // Pops fire on the read falling edge so the head is stable during the access
   assign w_a_pop = r_a_rd_d & ~a_rd;
   assign w_b_pop = r_b_rd_d & ~b_rd;

   jtkunio_mbox_fifo #(.DW(DW), .DEPTH(DEPTH)) u_a2b (
      .clk      (clk),
      .rst      (rst),
      .push     (r_a_push),
      .pop      (w_b_pop),
      .din      (a_din),
      .dout     (b_dout),
      .full     (w_a2b_full),
      .nempty   (w_a2b_nempty),
      .ovf      (a_ovf),
      .accepted (w_a2b_acc)
   );

   jtkunio_mbox_fifo #(.DW(DW), .DEPTH(DEPTH)) u_b2a (
      .clk      (clk),
      .rst      (rst),
      .push     (r_b_push),
      .pop      (w_a_pop),
      .din      (b_din),
      .dout     (a_dout),
      .full     (w_b2a_full),
      .nempty   (w_b2a_nempty),
      .ovf      (b_ovf),
      .accepted (w_b2a_acc)
   );

   assign a_st = {w_a2b_full, w_b2a_nempty};
   assign b_st = {w_b2a_full, w_a2b_nempty};

`ifdef JTKUNIO_MBOX_IRQLATCH_EN
   logic r_a_irq, r_b_irq;

   // Set has priority over a coincident clear
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a_irq <= 1'b0;
         r_b_irq <= 1'b0;
      end else begin
         if (w_b2a_acc)
            r_a_irq <= 1'b1;
         else if (a_irqclr)
            r_a_irq <= 1'b0;
         if (w_a2b_acc)
            r_b_irq <= 1'b1;
         else if (b_irqclr)
            r_b_irq <= 1'b0;
      end
   end

   assign a_irq = r_a_irq;
   assign b_irq = r_b_irq;
`else
   logic w_unused_irq;

   assign a_irq        = w_b2a_nempty;
   assign b_irq        = w_a2b_nempty;
   assign w_unused_irq = a_irqclr ^ b_irqclr ^ w_a2b_acc ^ w_b2a_acc;
`endif

endmodule
`default_nettype wire

// File: tb/tb_jtkunio_mbox.sv
`default_nettype none
// Bench for jtkunio_mbox: DEPTH=1 and DEPTH=4 instances share one random/directed
// stimulus stream and are compared every cycle against a queue-based mailbox model.
module tb_jtkunio_mbox;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       a_wr, a_rd, b_wr, b_rd, a_irqclr, b_irqclr;
   logic [7:0] a_din, b_din;
   logic [7:0] a_dout [2];
   logic [7:0] b_dout [2];
   logic [1:0] a_st [2];
   logic [1:0] b_st [2];
   logic       a_ovf [2];
   logic       b_ovf [2];
   logic       a_irq [2];
   logic       b_irq [2];

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   jtkunio_mbox #(.DW(8), .DEPTH(1)) u_d1 (
      .clk(clk), .rst(rst),
      .a_wr(a_wr), .a_rd(a_rd), .a_din(a_din), .a_dout(a_dout[0]), .a_st(a_st[0]),
      .a_ovf(a_ovf[0]), .a_irq(a_irq[0]), .a_irqclr(a_irqclr),
      .b_wr(b_wr), .b_rd(b_rd), .b_din(b_din), .b_dout(b_dout[0]), .b_st(b_st[0]),
      .b_ovf(b_ovf[0]), .b_irq(b_irq[0]), .b_irqclr(b_irqclr)
   );

   jtkunio_mbox #(.DW(8), .DEPTH(4)) u_d4 (
      .clk(clk), .rst(rst),
      .a_wr(a_wr), .a_rd(a_rd), .a_din(a_din), .a_dout(a_dout[1]), .a_st(a_st[1]),
      .a_ovf(a_ovf[1]), .a_irq(a_irq[1]), .a_irqclr(a_irqclr),
      .b_wr(b_wr), .b_rd(b_rd), .b_din(b_din), .b_dout(b_dout[1]), .b_st(b_st[1]),
      .b_ovf(b_ovf[1]), .b_irq(b_irq[1]), .b_irqclr(b_irqclr)
   );

   // Model: fifo index f = inst*2 + dir, dir 0 = A->B, dir 1 = B->A
   logic [7:0] mq [4][$];
   logic [7:0] md [4];
   bit         mo [4];
   bit         mi [4];
   bit a_wr_prev, a_rd_prev, b_wr_prev, b_rd_prev, a_pend, b_pend;

   function automatic int dep(int f);
      return (f < 2) ? 1 : 4;
   endfunction

   function automatic bit irq_exp(int f);
`ifdef JTKUNIO_MBOX_IRQLATCH_EN
      return mi[f];
`else
      return mq[f].size() != 0;
`endif
   endfunction

   task automatic m_step(int f, bit push, bit pop, logic [7:0] d, bit clr);
      bit acc = 1'b0;
      if (push && pop && mq[f].size() == 0) begin
         md[f] = d;
         acc   = 1'b1;
      end else begin
         if (pop && mq[f].size() != 0) mq[f].delete(0);
         if (push) begin
            if (mq[f].size() < dep(f)) begin
               mq[f].push_back(d);
               acc = 1'b1;
            end else begin
               mo[f] = 1'b1;
            end
         end
         if (mq[f].size() != 0) md[f] = mq[f][0];
      end
      if (acc) mi[f] = 1'b1;
      else if (clr) mi[f] = 1'b0;
   endtask

   initial forever begin
      @(posedge clk);
      if (rst) begin
         for (int f = 0; f < 4; f++) begin
            mq[f].delete();
            md[f] = 8'h00;
            mo[f] = 1'b0;
            mi[f] = 1'b0;
         end
         a_wr_prev = 1'b1; a_rd_prev = 1'b1; b_wr_prev = 1'b1; b_rd_prev = 1'b1;
         a_pend = 1'b0; b_pend = 1'b0;
      end else begin
         bit apop, bpop;
         apop = a_rd_prev && !a_rd;
         bpop = b_rd_prev && !b_rd;
         for (int i = 0; i < 2; i++) begin
            m_step(i*2,   a_pend, bpop, a_din, b_irqclr);
            m_step(i*2+1, b_pend, apop, b_din, a_irqclr);
         end
         a_pend = a_wr && !a_wr_prev;
         b_pend = b_wr && !b_wr_prev;
         a_wr_prev = a_wr; a_rd_prev = a_rd; b_wr_prev = b_wr; b_rd_prev = b_rd;
      end
   end

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            chk($sformatf("i%0d a_dout", i), 32'(a_dout[i]), 32'(md[i*2+1]));
            chk($sformatf("i%0d b_dout", i), 32'(b_dout[i]), 32'(md[i*2]));
            chk($sformatf("i%0d a_st", i), 32'(a_st[i]),
                32'({mq[i*2].size() == dep(i*2), mq[i*2+1].size() != 0}));
            chk($sformatf("i%0d b_st", i), 32'(b_st[i]),
                32'({mq[i*2+1].size() == dep(i*2+1), mq[i*2].size() != 0}));
            chk($sformatf("i%0d a_ovf", i), 32'(a_ovf[i]), 32'(mo[i*2]));
            chk($sformatf("i%0d b_ovf", i), 32'(b_ovf[i]), 32'(mo[i*2+1]));
            chk($sformatf("i%0d a_irq", i), 32'(a_irq[i]), 32'(irq_exp(i*2+1)));
            chk($sformatf("i%0d b_irq", i), 32'(b_irq[i]), 32'(irq_exp(i*2)));
         end
      end
   end

   task automatic tick(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic a_write(logic [7:0] d);
      a_wr = 1'b1; a_din = d;
      tick(3);
      a_wr = 1'b0;
      tick(2);
   endtask

   logic [7:0] exp4 [4];

   initial begin
      rst = 1'b1;
      a_wr = 0; a_rd = 0; b_wr = 0; b_rd = 0; a_irqclr = 0; b_irqclr = 0;
      a_din = 8'h00; b_din = 8'h00;
      exp4[0] = 8'h22; exp4[1] = 8'h33; exp4[2] = 8'h44; exp4[3] = 8'h66;
      tick(3);
      rst = 1'b0;
      chk_en = 1'b1;
      for (int i = 0; i < 2; i++) begin
         chk("rst a_dout", 32'(a_dout[i]), 0);
         chk("rst b_st", 32'(b_st[i]), 0);
         chk("rst a_irq", 32'(a_irq[i]), 0);
      end
      tick(2);

      // DEPTH=1 single-byte latch behaviour
      a_write(8'h5A);
      chk("d1 b_st after write", 32'(b_st[0]), 32'h1);
      chk("d1 b_irq after write", 32'(b_irq[0]), 1);
      b_rd = 1'b1;
      tick(2);
      chk("d1 b_dout during read", 32'(b_dout[0]), 32'h5A);
      b_rd = 1'b0;
      tick(1);
      chk("d1 b_st after read", 32'(b_st[0]), 0);
`ifdef JTKUNIO_MBOX_IRQLATCH_EN
      chk("d1 b_irq after read", 32'(b_irq[0]), 1);
`else
      chk("d1 b_irq after read", 32'(b_irq[0]), 0);
`endif
      tick(1);

      // DEPTH=4 fill and overflow
      a_write(8'h11); a_write(8'h22); a_write(8'h33); a_write(8'h44);
      chk("d4 full after 4", 32'(a_st[1][1]), 1);
      chk("d4 no ovf after 4", 32'(a_ovf[1]), 0);
      a_write(8'h55);
      chk("d4 ovf after 5", 32'(a_ovf[1]), 1);

      // Simultaneous pop and push while full
      b_rd = 1'b1;
      tick(2);
      chk("d4 head 11", 32'(b_dout[1]), 32'h11);
      a_wr = 1'b1; a_din = 8'h66;
      tick(1);
      b_rd = 1'b0;
      tick(1);
      chk("d4 still full", 32'(a_st[1][1]), 1);
      chk("d4 head 22", 32'(b_dout[1]), 32'h22);
      tick(1);
      a_wr = 1'b0;
      tick(2);
      for (int k = 0; k < 4; k++) begin
         b_rd = 1'b1;
         tick(2);
         chk($sformatf("d4 pop %0d", k), 32'(b_dout[1]), 32'(exp4[k]));
         b_rd = 1'b0;
         tick(2);
      end
      chk("d4 empty st", 32'(b_st[1]), 0);

      // Pop on empty holds dout
      b_rd = 1'b1; tick(2); b_rd = 1'b0; tick(2);
      chk("d4 empty pop dout", 32'(b_dout[1]), 32'h66);
      chk("d4 empty pop st", 32'(b_st[1]), 0);

      // Reset with a_wr held high
      a_wr = 1'b1; a_din = 8'h77;
      tick(1);
      rst = 1'b1; tick(2); rst = 1'b0;
      tick(4);
      chk("rst-held b_st", 32'(b_st[1]), 0);
      chk("rst-held b_dout", 32'(b_dout[1]), 0);
      chk("rst-held a_ovf", 32'(a_ovf[1]), 0);
      a_wr = 1'b0;
      tick(2);
      chk("rst-held no push", 32'(b_st[1]), 0);

      // IRQ set/clear interplay
      a_write(8'hA1);
      chk("irq after push", 32'(b_irq[1]), 1);
      a_wr = 1'b1; a_din = 8'hA2;
      tick(1);
      b_irqclr = 1'b1;
      tick(1);
      b_irqclr = 1'b0;
      tick(1);
      chk("irq set beats clr", 32'(b_irq[1]), 1);
      a_wr = 1'b0;
      tick(2);
      b_irqclr = 1'b1; tick(1); b_irqclr = 1'b0; tick(1);
`ifdef JTKUNIO_MBOX_IRQLATCH_EN
      chk("irq lone clr", 32'(b_irq[1]), 0);
`else
      chk("irq lone clr", 32'(b_irq[1]), 1);
`endif

      // Random traffic on both sides
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 3) == 0) a_wr = ~a_wr;
         if ($urandom_range(0, 4) == 0) a_rd = ~a_rd;
         if ($urandom_range(0, 3) == 0) b_wr = ~b_wr;
         if ($urandom_range(0, 4) == 0) b_rd = ~b_rd;
         a_din    = 8'($urandom);
         b_din    = 8'($urandom);
         a_irqclr = ($urandom_range(0, 7) == 0);
         b_irqclr = ($urandom_range(0, 7) == 0);
         rst      = ($urandom_range(0, 299) == 0);
         tick(1);
      end
      rst = 1'b0; a_irqclr = 1'b0; b_irqclr = 1'b0;
      tick(4);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
